// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Preload values apply only when REGFILE_INIT_PRELOAD_EN is defined.
package rf_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NREGS    = 32;
  localparam int unsigned MAX_WAIT = 4;

  localparam logic [31:0] PRELOAD_X1 = 32'h0000_000C;
  localparam logic [31:0] PRELOAD_X2 = 32'h0000_000D;

  typedef enum logic {
    StInit,
    StRun
  } arb_state_t;

  typedef enum logic [1:0] {
    GntNone,
    GntPipe,
    GntMdu
  } grant_t;

endpackage

// File: rtl/rf_init_seq.sv
// Post-reset init walker over x1..x(NREGS-1): index counter, last-index flag and init-value mux.
// REGFILE_INIT_PRELOAD_EN selects non-zero values for x1/x2; otherwise every register gets 0.
module rf_init_seq #(
  parameter int unsigned XLEN  = rf_pkg::XLEN,
  parameter int unsigned NREGS = rf_pkg::NREGS,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            advance_i,
  output logic [AW-1:0]   idx_o,
  output logic            done_o,
  output logic [XLEN-1:0] value_o
);
  import rf_pkg::*;

  logic [AW-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (advance_i) begin
      idx_d = idx_q + AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_q <= AW'(1);
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  // High while the final register is being issued.
  assign done_o = (idx_q == AW'(NREGS - 1));

  always_comb begin
    value_o = '0;
`ifdef REGFILE_INIT_PRELOAD_EN
    if (idx_q == AW'(1)) begin
      value_o = XLEN'(PRELOAD_X1);
    end else if (idx_q == AW'(2)) begin
      value_o = XLEN'(PRELOAD_X2);
    end
`endif
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the writeback stage (priority) and the MDU,
// after a post-reset init pass. REGFILE_INIT_PRELOAD_EN selects the preloaded init values.
module regfile_write_arbiter #(
  parameter int unsigned XLEN     = rf_pkg::XLEN,
  parameter int unsigned NREGS    = rf_pkg::NREGS,
  parameter int unsigned MAX_WAIT = rf_pkg::MAX_WAIT,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            pipe_valid_i,
  input  logic [AW-1:0]   pipe_rd_i,
  input  logic [XLEN-1:0] pipe_wdata_i,
  input  logic            mdu_valid_i,
  input  logic [AW-1:0]   mdu_rd_i,
  input  logic [XLEN-1:0] mdu_wdata_i,
  output logic            mdu_ready_o,
  output logic            stall_o,
  output logic            busy_o,
  output logic            rf_we_o,
  output logic [AW-1:0]   rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o
);
  import rf_pkg::*;

  localparam int unsigned WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  arb_state_t      state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  grant_t          gnt;

  logic [AW-1:0]   init_idx;
  logic            init_done;
  logic [XLEN-1:0] init_value;

  rf_init_seq #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_init_seq (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .advance_i (state_q == StInit),
    .idx_o     (init_idx),
    .done_o    (init_done),
    .value_o   (init_value)
  );

  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    gnt         = GntNone;
    stall_o     = 1'b0;
    mdu_ready_o = 1'b0;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;

    unique case (state_q)
      StInit: begin
        stall_o = 1'b1;
        we_d    = 1'b1;
        waddr_d = init_idx;
        wdata_d = init_value;
        if (init_done) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (mdu_valid_i && (wait_q == WW'(MAX_WAIT))) begin
          // Starvation guard: MDU takes the port and the pipe replays next cycle.
          gnt         = GntMdu;
          stall_o     = 1'b1;
          mdu_ready_o = 1'b1;
        end else if (pipe_valid_i) begin
          gnt = GntPipe;
          if (mdu_valid_i) begin
            wait_d = (wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + WW'(1);
          end
        end else if (mdu_valid_i) begin
          gnt         = GntMdu;
          mdu_ready_o = 1'b1;
        end
      end
      default: ;
    endcase

    // x0 writes complete the handshake but never assert the write enable.
    unique case (gnt)
      GntPipe: begin
        we_d    = (pipe_rd_i != '0);
        waddr_d = pipe_rd_i;
        wdata_d = pipe_wdata_i;
      end
      GntMdu: begin
        we_d    = (mdu_rd_i != '0);
        waddr_d = mdu_rd_i;
        wdata_d = mdu_wdata_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StInit;
      wait_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy_o     = (state_q == StInit);
  assign rf_we_o    = we_q;
  assign rf_waddr_o = waddr_q;
  assign rf_wdata_o = wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a write scoreboard.
// Honours REGFILE_INIT_PRELOAD_EN when computing the expected init values.
module tb_regfile_write_arbiter;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wdata;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_wdata;
  logic        mdu_ready;
  logic        stall;
  logic        busy;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  wr_t         sb[$];
  logic [4:0]  last_addr = '0;
  logic [31:0] last_data = '0;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .pipe_valid_i (pipe_valid),
    .pipe_rd_i    (pipe_rd),
    .pipe_wdata_i (pipe_wdata),
    .mdu_valid_i  (mdu_valid),
    .mdu_rd_i     (mdu_rd),
    .mdu_wdata_i  (mdu_wdata),
    .mdu_ready_o  (mdu_ready),
    .stall_o      (stall),
    .busy_o       (busy),
    .rf_we_o      (rf_we),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata)
  );

  function automatic logic [31:0] init_val(input int k);
`ifdef REGFILE_INIT_PRELOAD_EN
    if (k == 1) return 32'h0000_000C;
    if (k == 2) return 32'h0000_000D;
`endif
    return 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_we"}, {31'b0, rf_we}, 32'd0);
    chk({tag, "_addr"}, {27'b0, rf_waddr}, 32'd0);
    chk({tag, "_data"}, rf_wdata, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    chk({tag, "_stall"}, {31'b0, stall}, 32'd1);
    chk({tag, "_ready"}, {31'b0, mdu_ready}, 32'd0);
    last_addr = '0;
    last_data = '0;
  endtask

  // Called at a negedge with inputs already driven: checks the combinational handshake,
  // pushes the expected register-file write, then pops and compares it after the next edge.
  task automatic tick(input string tag, input bit e_ready, input bit e_stall, input bit e_busy,
                      input bit gnt, input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    wr_t got;
    #1;
    chk({tag, "_ready"}, {31'b0, mdu_ready}, {31'b0, e_ready});
    chk({tag, "_stall"}, {31'b0, stall}, {31'b0, e_stall});
    chk({tag, "_busy"}, {31'b0, busy}, {31'b0, e_busy});
    if (gnt) begin
      last_addr = rd;
      last_data = data;
    end
    e.we   = gnt && (rd != 5'd0);
    e.addr = last_addr;
    e.data = last_data;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, "_we"}, {31'b0, rf_we}, {31'b0, got.we});
    chk({tag, "_addr"}, {27'b0, rf_waddr}, {27'b0, got.addr});
    chk({tag, "_data"}, rf_wdata, got.data);
    @(negedge clk);
  endtask

  task automatic do_init(input string tag);
    for (int k = 1; k < 32; k++) begin
      tick($sformatf("%s_x%0d", tag, k), 1'b0, 1'b1, 1'b1, 1'b1, 5'(k), init_val(k));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    pipe_valid = 1'b0;
    pipe_rd    = '0;
    pipe_wdata = '0;
    mdu_valid  = 1'b0;
    mdu_rd     = '0;
    mdu_wdata  = '0;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    // Partial init, then reset while idx==10.
    for (int k = 1; k < 10; k++) begin
      tick($sformatf("init_a_x%0d", k), 1'b0, 1'b1, 1'b1, 1'b1, 5'(k), init_val(k));
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset("rst_mid_init");
    @(negedge clk);
    rst_n = 1'b1;
    do_init("init_b");

    // Pipe-only write.
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_wdata = 32'hDEAD_BEEF;
    tick("pipe_only", 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    pipe_valid = 1'b0;
    tick("idle0", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // Contention: MDU loses four times, then is forced through.
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_wdata = 32'h0000_1234;
    pipe_valid = 1'b1; pipe_rd = 5'd3;
    for (int i = 0; i < 4; i++) begin
      pipe_wdata = 32'hA000_0000 + i;
      tick($sformatf("cont_p%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'hA000_0000 + i);
    end
    pipe_wdata = 32'hA000_0004;
    tick("cont_force", 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_1234);
    mdu_valid = 1'b0;
    tick("cont_replay", 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'hA000_0004);
    pipe_valid = 1'b0;
    tick("idle1", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // MDU write to x0: handshake completes, no write enable.
    mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_wdata = 32'h0000_0055;
    tick("x0_mdu", 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_0055);
    mdu_valid = 1'b0;
    tick("x0_hold", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // MDU valid toggling under continuous pipe traffic never reaches the guard.
    pipe_valid = 1'b1; pipe_rd = 5'd9;
    mdu_rd = 5'd11; mdu_wdata = 32'h0000_0077;
    for (int i = 0; i < 10; i++) begin
      mdu_valid  = (i % 2 == 0);
      pipe_wdata = 32'hB000_0000 + i;
      tick($sformatf("alt%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'hB000_0000 + i);
    end
    pipe_valid = 1'b0; mdu_valid = 1'b1;
    tick("alt_mdu", 1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 32'h0000_0077);
    mdu_valid = 1'b0;

    // Same rd from both: pipe first, MDU later, MDU value is the final one.
    pipe_valid = 1'b1; pipe_rd = 5'd20; pipe_wdata = 32'h1;
    mdu_valid = 1'b1; mdu_rd = 5'd20; mdu_wdata = 32'h2;
    tick("same_pipe", 1'b0, 1'b0, 1'b0, 1'b1, 5'd20, 32'h1);
    pipe_valid = 1'b0;
    tick("same_mdu", 1'b1, 1'b0, 1'b0, 1'b1, 5'd20, 32'h2);
    mdu_valid = 1'b0;

    // Reset with wait count at 3; the count must restart from zero after init.
    pipe_valid = 1'b1; pipe_rd = 5'd4; pipe_wdata = 32'hC000_0000;
    mdu_valid = 1'b1; mdu_rd = 5'd13; mdu_wdata = 32'h0000_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick($sformatf("prew%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 32'hC000_0000);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset("rst_mid_wait");
    @(negedge clk);
    rst_n = 1'b1;
    do_init("init_c");
    for (int i = 0; i < 4; i++) begin
      tick($sformatf("postw%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 32'hC000_0000);
    end
    tick("postw_force", 1'b1, 1'b1, 1'b0, 1'b1, 5'd13, 32'h0000_BEEF);
    mdu_valid = 1'b0;
    tick("postw_replay", 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 32'hC000_0000);
    pipe_valid = 1'b0;
    tick("idle2", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 32-entry register file and shares it between two requesters.
- Requester 1: pipeline writeback stage (priority).
- Requester 2: a long-latency unit (MDU/divider), using a valid/ready handshake.
- After reset it runs an init sequence over x1..x31 before accepting traffic. An MDU starvation guard forces the pipeline to stall for one cycle.

Parameters:
- XLEN, 32, data width.
- NREGS, 32, register count; address width is log2(NREGS).
- MAX_WAIT, 4, number of consecutive cycles a valid MDU request may lose before it is forced through.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- pipe_valid  in  1  writeback stage has a register write this cycle.
- pipe_rd  in  5  writeback destination.
- pipe_wdata  in  XLEN  writeback data.
- mdu_valid  in  1  MDU result pending; held with stable rd/data until accepted.
- mdu_rd  in  5  MDU destination.
- mdu_wdata  in  XLEN  MDU data.
- mdu_ready  out  1  MDU result accepted this cycle.
- stall  out  1  pipeline must freeze; its pipe_* write is not taken and is re-presented next cycle.
- busy  out  1  init sequence in progress.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  XLEN  register-file write data.

Behaviour:
- Reset:
  - reset==0 sampled at a clk edge sets state=INIT, idx=1, wait_cnt=0.
  - Registered outputs clear: rf_we=0, rf_waddr=0, rf_wdata=0.
  - Reset asserted mid-INIT or mid-RUN restarts INIT from idx=1. An unaccepted MDU request is simply re-presented later.
- States: INIT, RUN.
- INIT:
  - One write per cycle; register the write rf_we=1, rf_waddr=idx, rf_wdata=init value (0).
  - idx increments each cycle. When idx==NREGS-1 is issued, the next state is RUN.
  - Total of 31 writes; first rf_we appears the cycle after reset deasserts.
  - Throughout INIT: busy=1, stall=1, mdu_ready=0. busy falls combinationally on the first RUN cycle.
- RUN arbitration, evaluated per cycle:
  - Case 1: if mdu_valid && wait_cnt==MAX_WAIT, grant MDU, assert stall=1 and mdu_ready=1. The pipe write is not taken.
  - Case 2: else if pipe_valid, grant pipe with stall=0 and mdu_ready=0. If mdu_valid, wait_cnt++ (saturating at MAX_WAIT).
  - Case 3: else if mdu_valid, grant MDU with mdu_ready=1.
  - Case 4: else no grant.
  - wait_cnt clears on any MDU grant, or in any cycle with mdu_valid==0.
- mdu_ready and stall are combinational from state, wait_cnt and the valids. There is no combinational path from *_wdata.
- Write latency: the granted write appears on rf_we/rf_waddr/rf_wdata one cycle after grant.
- rd==0 is consumed but not written:
  - A granted request with rd==0 produces rf_we=0. The handshake still completes (mdu_ready=1 for MDU).
  - rf_waddr and rf_wdata still update.
- Outputs hold their last values when there is no grant, with rf_we=0.
- Simultaneous pipe and MDU requests to the same rd:
  - Only the granted one writes that cycle; the other writes later, so the last writer wins.
  - Ordering between the units is the hazard unit's responsibility.

Optional Feature:
- Macro REGFILE_INIT_PRELOAD_EN.
- Defined: INIT writes x1=0x0000000C and x2=0x0000000D; all other registers get 0.
- Undefined: INIT writes 0 to x1..x31.
- Sequence length and timing are identical either way.

Decomposition:
- Shared package rf_pkg holds:
  - XLEN and NREGS constants.
  - arb_state_t enum {INIT, RUN}.
  - grant_t enum {GNT_NONE, GNT_PIPE, GNT_MDU}.
  - Preload value constants.
- One natural sub-module: rf_init_seq, holding the idx counter, done flag and init-value mux.
- The arbiter core stays in the top module.

Test Plan:
- Init: hold reset=0 for 2 cycles, then release; expect 31 writes x1..x31 on consecutive cycles with data 0 (preload on: x1=0xC, x2=0xD), busy high for 31 cycles, stall high throughout.
- Pipe-only: pipe_valid rd=5 data=0xDEADBEEF in RUN; next cycle expect rf_we=1, addr=5, data=0xDEADBEEF, stall=0.
- Contention: pipe_valid continuous and mdu_valid (rd=7, data=0x1234) from cycle 0; expect mdu_ready=0 for 4 cycles, then cycle 4 mdu_ready=1 and stall=1, with rf write addr=7 data=0x1234 the following cycle. The stalled pipe write lands the cycle after that.
- x0 discard: MDU rd=0 with pipe idle; expect mdu_ready=1 and rf_we=0 next cycle.
- Reset mid-operation: assert reset=0 during INIT at idx=10 and again during a pending MDU wait (wait_cnt=3); expect INIT to restart at idx=1 with wait_cnt=0 and mdu_ready=0 until RUN.
- Idle MDU: mdu_valid alternating on pipe-busy cycles; expect wait_cnt to clear whenever mdu_valid drops, so no forced stall occurs.
